// File: rtl/out_display.sv
// -----------------------------------------------------------------------------
// out_display
//
// Output stage of the SAP-1 datapath. It captures the W bus into the output
// register when the controller pulls n_lo low. A sequential double-dabble
// converter then turns the byte into three BCD digits, one shift per clock.
// The digits are time-multiplexed onto a common 7-segment display, and leading
// zeros are blanked.
//
// Ports
//   clk      in   1   system clock, rising edge
//   clr      in   1   synchronous active-high reset
//   n_lo     in   1   active-low output-register load strobe
//   dbus     in   8   W bus
//   out_reg  out  8   captured binary value
//   bcd      out  12  {hundreds, tens, ones} of the last completed conversion
//   busy     out  1   conversion in progress
//   an       out  3   one-hot digit enable (an[0] = ones, an[2] = hundreds)
//   seg      out  7   active-high segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module out_display #(
    parameter int SCAN_DIV = 1024
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        n_lo,
    input  logic [7:0]  dbus,
    output logic [7:0]  out_reg,
    output logic [11:0] bcd,
    output logic        busy,
    output logic [2:0]  an,
    output logic [6:0]  seg
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    // Double-dabble correction: a nibble of 5 or more would reach 10 or more
    // after the next shift, so 3 is added first. The carry stays inside the
    // nibble.
    function automatic logic [3:0] adj_nibble(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    state_t          state_q, state_d;
    logic [19:0]     sr_q, sr_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [7:0]      out_reg_q, out_reg_d;
    logic [11:0]     bcd_q, bcd_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [1:0]      idx_q, idx_d;

    logic [19:0]     sr_adj;
    logic [19:0]     sr_shift;
    logic [3:0]      digit;
    logic            blank;

    assign sr_adj   = {adj_nibble(sr_q[19:16]), adj_nibble(sr_q[15:12]),
                       adj_nibble(sr_q[11:8]), sr_q[7:0]};
    assign sr_shift = sr_adj << 1;

    // Conversion FSM, next state
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        out_reg_d = out_reg_q;
        bcd_d     = bcd_q;

        if (!n_lo) begin
            // A load always wins, even in the middle of a conversion. The
            // aborted conversion never reaches bcd.
            out_reg_d = dbus;
            sr_d      = {12'b0, dbus};
            cnt_d     = 3'd0;
            state_d   = CONV;
        end else begin
            case (state_q)
                CONV: begin
                    sr_d  = sr_shift;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        bcd_d   = sr_shift[19:8];
                        state_d = IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Scan prescaler and digit index, free-running and independent of loads
    always_comb begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            idx_d   = (idx_q == 2'd2) ? 2'd0 : (idx_q + 2'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            out_reg_q <= 8'd0;
            bcd_q     <= 12'd0;
            presc_q   <= '0;
            idx_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_reg_q <= out_reg_d;
            bcd_q     <= bcd_d;
            presc_q   <= presc_d;
            idx_q     <= idx_d;
        end
    end

    // The shift register is only meaningful in CONV, and every entry to CONV
    // reloads it, so it needs no reset.
    always_ff @(posedge clk) begin
        sr_q <= sr_d;
    end

    // Digit select, leading-zero blanking and segment decode
    always_comb begin
        digit = bcd_q[3:0];
        blank = 1'b0;
        case (idx_q)
            2'd1: begin
                digit = bcd_q[7:4];
                blank = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
            end
            2'd2: begin
                digit = bcd_q[11:8];
                blank = (bcd_q[11:8] == 4'd0);
            end
            default: begin
            end
        endcase
        seg = blank ? 7'b0000000 : seg_decode(digit);
        an  = 3'b001 << idx_q;
    end

    assign out_reg = out_reg_q;
    assign bcd     = bcd_q;
    assign busy    = (state_q == CONV);

endmodule

// File: tb/tb_out_display.sv
module tb_out_display;

    logic        clk = 1'b0;
    logic        clr;
    logic        n_lo;
    logic [7:0]  dbus;
    logic [7:0]  out_reg;
    logic [11:0] bcd;
    logic        busy;
    logic [2:0]  an;
    logic [6:0]  seg;

    int total = 0;
    int bad   = 0;

    out_display #(.SCAN_DIV(2)) dut (
        .clk     (clk),
        .clr     (clr),
        .n_lo    (n_lo),
        .dbus    (dbus),
        .out_reg (out_reg),
        .bcd     (bcd),
        .busy    (busy),
        .an      (an),
        .seg     (seg)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1; n_lo = 1'b1; dbus = 8'h5A;
        step(); step();
        total++; if (out_reg !== 8'd0)  begin bad++; $display("FAIL reset_out_reg got=%h want=00", out_reg); end
        total++; if (bcd !== 12'h000)   begin bad++; $display("FAIL reset_bcd got=%h want=000", bcd); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (an !== 3'b001)     begin bad++; $display("FAIL reset_an got=%b want=001", an); end
        total++; if (seg !== 7'b0111111) begin bad++; $display("FAIL reset_seg got=%b want=0111111", seg); end
        clr = 1'b0;
    endtask

    task automatic test_full_scale();
        logic [2:0] a0;
        logic [2:0] exp_an;
        logic [6:0] exp_seg;
        int n;
        n_lo = 1'b0; dbus = 8'd255;
        step();
        n_lo = 1'b1; dbus = 8'($urandom);
        total++; if (out_reg !== 8'hFF) begin bad++; $display("FAIL fs_out_reg got=%h want=ff", out_reg); end
        total++; if (busy !== 1'b1)     begin bad++; $display("FAIL fs_busy_e0 got=%b want=1", busy); end
        for (int i = 1; i < 8; i++) begin
            step();
            total++; if (busy !== 1'b1 || bcd !== 12'h000) begin
                bad++; $display("FAIL fs_busy_hold cyc=%0d busy=%b bcd=%h want busy=1 bcd=000", i, busy, bcd);
            end
        end
        step();
        total++; if (busy !== 1'b0)   begin bad++; $display("FAIL fs_busy_done got=%b want=0", busy); end
        total++; if (bcd !== 12'h255) begin bad++; $display("FAIL fs_bcd got=%h want=255", bcd); end
        // Align to a digit change, then expect a 2-cycle dwell per digit.
        a0 = an; n = 0;
        while (an === a0 && n < 4) begin step(); n++; end
        total++; if (an === a0) begin bad++; $display("FAIL fs_scan_stuck an=%b never changed", an); end
        exp_an = an;
        for (int c = 0; c < 6; c++) begin
            if (c == 2 || c == 4) exp_an = {exp_an[1:0], exp_an[2]};
            case (exp_an)
                3'b001:  exp_seg = 7'b1101101;
                3'b010:  exp_seg = 7'b1101101;
                default: exp_seg = 7'b1011011;
            endcase
            total++; if (an !== exp_an || seg !== exp_seg) begin
                bad++; $display("FAIL fs_scan c=%0d an=%b seg=%b want an=%b seg=%b", c, an, seg, exp_an, exp_seg);
            end
            step();
        end
    endtask

    task automatic test_blanking();
        logic [6:0] exp_seg;
        n_lo = 1'b0; dbus = 8'd7;
        step();
        n_lo = 1'b1;
        for (int i = 0; i < 8; i++) step();
        total++; if (bcd !== 12'h007 || busy !== 1'b0) begin bad++; $display("FAIL blank7_bcd got=%h busy=%b want=007 0", bcd, busy); end
        for (int c = 0; c < 6; c++) begin
            case (an)
                3'b001:  exp_seg = 7'b0000111;
                default: exp_seg = 7'b0000000;
            endcase
            total++; if (seg !== exp_seg) begin bad++; $display("FAIL blank7_seg an=%b got=%b want=%b", an, seg, exp_seg); end
            step();
        end
        n_lo = 1'b0; dbus = 8'd100;
        step();
        n_lo = 1'b1;
        for (int i = 0; i < 8; i++) step();
        total++; if (bcd !== 12'h100) begin bad++; $display("FAIL blank100_bcd got=%h want=100", bcd); end
        for (int c = 0; c < 6; c++) begin
            case (an)
                3'b100:  exp_seg = 7'b0000110;
                default: exp_seg = 7'b0111111;
            endcase
            total++; if (seg !== exp_seg) begin bad++; $display("FAIL blank100_seg an=%b got=%b want=%b", an, seg, exp_seg); end
            step();
        end
    endtask

    task automatic test_restart();
        n_lo = 1'b0; dbus = 8'd42;
        step();
        n_lo = 1'b1;
        step(); step();
        n_lo = 1'b0; dbus = 8'd199;
        step();
        n_lo = 1'b1;
        total++; if (out_reg !== 8'd199) begin bad++; $display("FAIL rs_out_reg got=%0d want=199", out_reg); end
        for (int i = 1; i < 8; i++) begin
            step();
            total++; if (bcd !== 12'h100 || busy !== 1'b1) begin
                bad++; $display("FAIL rs_hold cyc=%0d bcd=%h busy=%b want bcd=100 busy=1", i, bcd, busy);
            end
        end
        step();
        total++; if (bcd !== 12'h199 || busy !== 1'b0) begin bad++; $display("FAIL rs_bcd got=%h busy=%b want=199 0", bcd, busy); end
    endtask

    task automatic test_back_to_back();
        n_lo = 1'b0; dbus = 8'd10; step();
        dbus = 8'd20; step();
        dbus = 8'd30; step();
        n_lo = 1'b1;
        for (int i = 1; i < 8; i++) begin
            step();
            total++; if (busy !== 1'b1 || bcd !== 12'h199) begin
                bad++; $display("FAIL b2b_hold cyc=%0d busy=%b bcd=%h want 1 199", i, busy, bcd);
            end
        end
        step();
        total++; if (bcd !== 12'h030 || out_reg !== 8'd30) begin bad++; $display("FAIL b2b_bcd got=%h out=%0d want=030 30", bcd, out_reg); end
    endtask

    task automatic test_reset_mid_conv();
        n_lo = 1'b0; dbus = 8'd128;
        step();
        n_lo = 1'b1;
        step(); step(); step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        total++; if (bcd !== 12'h000 || busy !== 1'b0 || out_reg !== 8'd0) begin
            bad++; $display("FAIL rmc_clr bcd=%h busy=%b out=%h want 000 0 00", bcd, busy, out_reg);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            total++; if (bcd !== 12'h000 || busy !== 1'b0) begin
                bad++; $display("FAIL rmc_stale cyc=%0d bcd=%h busy=%b want 000 0", i, bcd, busy);
            end
        end
        clr = 1'b1; n_lo = 1'b0; dbus = 8'd77;
        step();
        clr = 1'b0; n_lo = 1'b1;
        total++; if (out_reg !== 8'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL collide out=%h busy=%b want 00 0", out_reg, busy);
        end
        for (int i = 0; i < 9; i++) step();
        total++; if (bcd !== 12'h000 || busy !== 1'b0) begin
            bad++; $display("FAIL collide_late bcd=%h busy=%b want 000 0", bcd, busy);
        end
    endtask

    task automatic test_no_strobe();
        n_lo = 1'b0; dbus = 8'd99;
        step();
        n_lo = 1'b1;
        for (int i = 0; i < 8; i++) step();
        total++; if (bcd !== 12'h099) begin bad++; $display("FAIL ns_setup bcd=%h want=099", bcd); end
        for (int i = 0; i < 50; i++) begin
            dbus = 8'($urandom);
            step();
            total++; if (out_reg !== 8'd99 || bcd !== 12'h099 || busy !== 1'b0) begin
                bad++; $display("FAIL ns_hold cyc=%0d out=%0d bcd=%h busy=%b want 99 099 0", i, out_reg, bcd, busy);
            end
        end
    endtask

    initial begin
        clr = 1'b1; n_lo = 1'b1; dbus = 8'd0;
        test_reset();
        test_full_scale();
        test_blanking();
        test_restart();
        test_back_to_back();
        test_reset_mid_conv();
        test_no_strobe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
